// File: rtl/data_shifter_left.sv
`default_nettype none
// ============================================================================
//  Module   : data_shifter_left
//  Purpose  : Small synchronous FIFO between the 16-bit processing path and
//             the 24-bit codec writer. Each stored sample is sign-extended to
//             24 bits and shifted left by SHIFT bits on the way out. The low
//             SHIFT bits are zero.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH     : FIFO entry count (power of two, 2..16)
//    SHIFT     : left-shift amount applied on output (0..8)
//  Ports
//    clk       : in   single clock, all state on the rising edge
//    rst_n     : in   asynchronous active-low reset
//    enn       : in   block enable; low on an edge flushes the FIFO
//    data_in   : in   [15:0] signed input sample
//    in_valid  : in   data_in is valid
//    in_ready  : out  block accepts data_in this cycle
//    data_out  : out  [23:0] signed expanded head sample (zero when invalid)
//    out_valid : out  data_out is valid
//    out_ready : in   downstream consumes data_out this cycle
//    count     : out  [clog2(DEPTH):0] current FIFO occupancy
// ============================================================================
module data_shifter_left #(
  parameter int DEPTH = 4,
  parameter int SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enn,
  input  logic [15:0]              data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [23:0]              data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                   c_PTR_W = $clog2(DEPTH);
  localparam int                   c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]   c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0]   c_PTR_1 = c_PTR_W'(1);

  // Storage array: contents are never reset; they are only observable through
  // data_out, which is forced to zero whenever out_valid is low.
  logic [15:0]              r_mem [DEPTH];

  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_CNT_W-1:0]       r_count;

  logic                     w_in_ready;
  logic                     w_out_valid;
  logic                     w_push;
  logic                     w_pop;
  logic [15:0]              w_head;
  logic [23:0]              w_head_ext;
  logic [23:0]              w_head_shifted;

  // --------------------------------------------------------------------------
  // Handshake decode. Both flags depend only on registered occupancy and the
  // enable, never on the opposite handshake, so a full FIFO refuses a push
  // even when a pop happens in the same cycle. rst_n gates in_ready so the
  // block reads as not-ready while held in reset, yet the first edge after
  // release can already accept a sample.
  // --------------------------------------------------------------------------
  assign w_in_ready  = rst_n && enn && (r_count < c_DEPTH);
  assign w_out_valid = enn && (r_count != '0);

  assign w_push = in_valid && w_in_ready;
  assign w_pop  = w_out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Output formatting: sign-extend the head to 24 bits, then shift left.
  // With SHIFT <= 8 the 16-bit sample plus shift always fits in 24 bits, so
  // the sign bit lands in bit 23 and the value is preserved exactly.
  // --------------------------------------------------------------------------
  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_ext     = {{8{w_head[15]}}, w_head};
  assign w_head_shifted = w_head_ext << SHIFT;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign data_out  = w_out_valid ? w_head_shifted : 24'h000000;
  assign count     = r_count;

  // --------------------------------------------------------------------------
  // Storage write. Pointers are exactly clog2(DEPTH) bits wide and DEPTH is a
  // power of two, so increments wrap modulo DEPTH without extra logic.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Pointer and occupancy state. A low enable on an edge flushes the FIFO;
  // push and pop are already suppressed in that cycle by the handshake
  // decode, so the flush branch only has to clear the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!enn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_1;
      end
      // Simultaneous push and pop leaves occupancy unchanged. Push is only
      // possible below DEPTH and pop only above zero, so the counter cannot
      // overflow or underflow.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_shifter_left.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_shifter_left
//  Purpose  : Directed self-checking bench for data_shifter_left
//             (DEPTH=4, SHIFT=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_shifter_left;

  logic        clk;
  logic        rst_n;
  logic        enn;
  logic [15:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  int checks;
  int errors;

  data_shifter_left #(.DEPTH(4), .SHIFT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enn       (enn),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away
  // from the edge and new inputs are applied for the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 16'h0;
    #5;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready actual=%b required=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    checks++; if (data_out !== 24'h000000) begin errors++; $display("FAIL reset_data_out actual=%h required=000000", data_out); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready actual=%b required=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; data_in = 16'h01E2;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid actual=%b required=1", out_valid); end
    checks++; if (data_out !== 24'h01E200) begin errors++; $display("FAIL basic_data actual=%h required=01e200", data_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count actual=%0d required=1", count); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count_pop actual=%0d required=0", count); end
    checks++; if (out_valid !== 1'b0 || data_out !== 24'h0) begin errors++; $display("FAIL basic_empty actual=%b/%h required=0/000000", out_valid, data_out); end
  endtask

  task automatic test_sign();
    out_ready = 1'b0; in_valid = 1'b1; data_in = 16'hF604;
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== 24'hF60400) begin errors++; $display("FAIL sign_data actual=%h required=f60400", data_out); end
    checks++; if ($signed(data_out) !== -24'sd654336) begin errors++; $display("FAIL sign_value actual=%0d required=-654336", $signed(data_out)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sign_drain actual=%0d required=0", count); end
  endtask

  task automatic test_full();
    logic [23:0] exp_q [5];
    int k;
    exp_q[0] = 24'h000100; exp_q[1] = 24'h000200; exp_q[2] = 24'h000300;
    exp_q[3] = 24'h000400; exp_q[4] = 24'h000500;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; data_in = 16'(i);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count actual=%0d required=4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready actual=%b required=0", in_ready); end
    in_valid = 1'b1; data_in = 16'd5;
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_held_count actual=%0d required=4", count); end
    // Pop with the 5th sample still offered: it must be refused on the pop
    // cycle and accepted once space exists.
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_push_on_pop actual=%b required=0", in_ready); end
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      logic pushing;
      pushing = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (data_out !== exp_q[k]) begin errors++; $display("FAIL full_order[%0d] actual=%h required=%h", k, data_out, exp_q[k]); end
        k++;
      end
      step();
      if (pushing) in_valid = 1'b0;
    end
    checks++; if (k != 5) begin errors++; $display("FAIL full_drain_timeout actual=%0d required=5", k); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_final_count actual=%0d required=0", count); end
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] head;
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 16'h0020; step();
    data_in = 16'h0021; step();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_prefill actual=%0d required=2", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      head = 16'h0020 + 16'(i);
      data_in = 16'h0022 + 16'(i);
      checks++;
      if (count !== 3'd2 || data_out !== {head, 8'h00}) begin
        errors++; $display("FAIL b2b_cycle[%0d] actual=%0d/%h required=2/%h", i, count, data_out, {head, 8'h00});
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (data_out !== 24'h002A00) begin errors++; $display("FAIL b2b_tail0 actual=%h required=002a00", data_out); end
    step();
    checks++; if (data_out !== 24'h002B00) begin errors++; $display("FAIL b2b_tail1 actual=%h required=002b00", data_out); end
    step();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty actual=%0d/%b required=0/0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_in = 16'h0030 + 16'(i); step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_prefill actual=%0d required=3", count); end
    enn = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || data_out !== 24'h0) begin
      errors++; $display("FAIL flush_disabled_outputs actual=%b/%b/%h required=0/0/000000", in_ready, out_valid, data_out);
    end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count actual=%0d required=0", count); end
    enn = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || data_out !== 24'h0) begin errors++; $display("FAIL flush_no_stale actual=%b/%h required=0/000000", out_valid, data_out); end
    in_valid = 1'b1; data_in = 16'h0010;
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== 24'h001000 || count !== 3'd1) begin errors++; $display("FAIL flush_reenable actual=%h/%0d required=001000/1", data_out, count); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_in = 16'h0040 + 16'(i); step();
    end
    in_valid = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 || data_out !== 24'h0) begin
      errors++; $display("FAIL midreset_outputs actual=%0d/%b/%b/%h required=0/0/0/000000", count, in_ready, out_valid, data_out);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL midreset_stale[%0d] actual=%b/%0d required=0/0", i, out_valid, count); end
    end
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 16'h0055;
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== 24'h005500 || count !== 3'd1) begin errors++; $display("FAIL midreset_first_push actual=%h/%0d required=005500/1", data_out, count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_sign();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
